// File: rtl/lsu_ahb_swc.sv
// lsu_ahb_swc: turns one EXU load/store request into a single AHB-Lite transfer to DTCM.
// Defining LSU_TIMEOUT_EN adds a data-phase watchdog that aborts after TIMEOUT HREADY-low cycles.
//   state | meaning
//   IDLE  | ready for a new request
//   ADDR  | address phase, NONSEQ driven on the bus
//   DATA  | data phase, waiting for hready
//   ERR2  | second cycle of a two-cycle ERROR response
//   MIS   | misaligned or illegal request, reporting error
module lsu_ahb_swc #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hrstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [1:0]        htrans,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              load_en,
    output logic [4:0]        load_rd,
    output logic [DATA_W-1:0] load_data,
    output logic              store_done,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int LB = $clog2(DATA_W / 8);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] ERR_MIS  = 2'b01;
    localparam logic [1:0] ERR_RESP = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR2, S_MIS} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [1:0]          size_q;
    logic                sext_q;
    logic [4:0]          rd_q;
    logic [1:0]          htrans_q;
    logic [DATA_W-1:0]   hwdata_q;
    logic                req_ready_q;
    logic                load_en_q;
    logic [4:0]          load_rd_q;
    logic [DATA_W-1:0]   load_data_q;
    logic                store_done_q;
    logic                err_valid_q;
    logic [1:0]          err_code_q;
    logic [ADDR_W-1:0]   err_addr_q;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ERR_TMO = 2'b11;
    logic [CW-1:0] wait_cnt_q;
`endif

    function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] size);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = a[0];
            2'd2:    mis = |a[1:0];
            default: mis = (DATA_W == 32) || (|a);
        endcase
        return mis;
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d, input logic [1:0] size);
        logic [DATA_W-1:0] r;
        case (size)
            2'd0:    r = {(DATA_W/8){d[7:0]}};
            2'd1:    r = {(DATA_W/16){d[15:0]}};
            2'd2:    r = {(DATA_W/32){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // mask keeps the access-size low bits; top marks the field's sign bit
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] rdata,
                                                  input logic [LB-1:0]     lane,
                                                  input logic [1:0]        size,
                                                  input logic              sext);
        logic [DATA_W-1:0] field;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] top;
        int                nbits;
        field = rdata >> {lane, 3'b000};
        nbits = 8 << size;
        if (nbits >= DATA_W) return rdata;
        mask = {DATA_W{1'b1}} >> (DATA_W - nbits);
        top  = mask ^ (mask >> 1);
        if (sext && (|(field & top))) return field | ~mask;
        return field & mask;
    endfunction

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            sext_q       <= 1'b0;
            rd_q         <= 5'd0;
            htrans_q     <= HTRANS_IDLE;
            hwdata_q     <= '0;
            req_ready_q  <= 1'b1;
            load_en_q    <= 1'b0;
            load_rd_q    <= 5'd0;
            load_data_q  <= '0;
            store_done_q <= 1'b0;
            err_valid_q  <= 1'b0;
            err_code_q   <= 2'b00;
            err_addr_q   <= '0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            load_en_q    <= 1'b0;
            store_done_q <= 1'b0;
            err_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        write_q     <= req_write;
                        size_q      <= req_size;
                        sext_q      <= req_sext;
                        rd_q        <= req_rd;
                        hwdata_q    <= replicate(req_wdata, req_size);
                        req_ready_q <= 1'b0;
                        if (is_misaligned(req_addr[2:0], req_size)) begin
                            state_q     <= S_MIS;
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_MIS;
                            err_addr_q  <= req_addr;
                        end else begin
                            state_q  <= S_ADDR;
                            htrans_q <= HTRANS_NONSEQ;
                        end
                    end
                end
                S_MIS: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                S_ADDR: begin
                    if (hready) begin
                        state_q  <= S_DATA;
                        htrans_q <= HTRANS_IDLE;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                S_DATA: begin
                    if (hready) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        if (hresp) begin
                            err_valid_q <= 1'b1;
                            err_code_q  <= ERR_RESP;
                            err_addr_q  <= addr_q;
                        end else if (write_q) begin
                            store_done_q <= 1'b1;
                        end else begin
                            load_en_q   <= 1'b1;
                            load_rd_q   <= rd_q;
                            load_data_q <= extract(hrdata, addr_q[LB-1:0], size_q, sext_q);
                        end
                    end else if (hresp) begin
                        state_q <= S_ERR2;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_TMO;
                        err_addr_q  <= addr_q;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                S_ERR2: begin
                    if (hready) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_RESP;
                        err_addr_q  <= addr_q;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    htrans_q    <= HTRANS_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign haddr      = addr_q;
    assign hwrite     = write_q;
    assign hsize      = {1'b0, size_q};
    assign htrans     = htrans_q;
    assign hburst     = 3'b000;
    assign hwdata     = hwdata_q;
    assign load_en    = load_en_q;
    assign load_rd    = load_rd_q;
    assign load_data  = load_data_q;
    assign store_done = store_done_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_lsu_ahb_swc.sv
// tb_lsu_ahb_swc: directed transactions push expected completions into a queue; a monitor
// pops and checks each load_en/store_done/err_valid pulse, including its cycle of arrival.
module tb_lsu_ahb_swc;

    logic        hclk = 1'b0;
    logic        hrstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic        load_en;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic        store_done;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_addr;

    lsu_ahb_swc #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .hclk(hclk), .hrstn(hrstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
        .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
        .hresp(hresp),
        .load_en(load_en), .load_rd(load_rd), .load_data(load_data),
        .store_done(store_done), .err_valid(err_valid), .err_code(err_code),
        .err_addr(err_addr)
    );

    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  code;
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // kind: 1 load, 2 store, 3 error
    always @(negedge hclk) begin
        if (hrstn === 1'b1 && (load_en || store_done || err_valid)) begin
            exp_t e;
            int   kind;
            kind = load_en ? 1 : (store_done ? 2 : 3);
            chk("pulse_exclusive", 64'(int'(load_en) + int'(store_done) + int'(err_valid)), 64'd1);
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, none expected", kind, cyc);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", 64'(kind), 64'(e.kind));
                chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                if (e.kind == 1) begin
                    chk("load_rd", 64'(load_rd), 64'(e.rd));
                    chk("load_data", 64'(load_data), 64'(e.data));
                end
                if (e.kind == 3) begin
                    chk("err_code", 64'(err_code), 64'(e.code));
                    chk("err_addr", 64'(err_addr), 64'(e.addr));
                end
                if (!(e.kind == 3 && e.code == 2'b01))
                    chk("req_ready_with_pulse", 64'(req_ready), 64'd1);
            end
        end
    end

    // mode: 0 normal, 1 misaligned, 2 HRESP error, 3 watchdog timeout
    task automatic txn(input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] rdata, input int waits, input int mode,
                       input logic [31:0] exp_data, input logic [31:0] exp_hwdata);
        exp_t e;
        int   acc;
        @(negedge hclk);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge hclk);
        if (!req_ready) chk("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_sext  = sx;
        req_addr  = addr;
        req_wdata = wd;
        req_rd    = rd;
        acc = cyc;
        e.rd = rd; e.data = exp_data; e.addr = addr; e.code = 2'b00;
        case (mode)
            1:       begin e.kind = 3; e.code = 2'b01; e.cyc = acc + 1; end
            2:       begin e.kind = 3; e.code = 2'b10; e.cyc = acc + 4; end
            3:       begin e.kind = 3; e.code = 2'b11; e.cyc = acc + 18; end
            default: begin e.kind = wr ? 2 : 1; e.cyc = acc + 3 + waits; end
        endcase
        sbq.push_back(e);
        @(posedge hclk);
        @(negedge hclk);
        req_valid = 1'b0;
        if (mode == 1) begin
            chk("mis_htrans", 64'(htrans), 64'd0);
            chk("mis_req_ready", 64'(req_ready), 64'd0);
            @(negedge hclk);
            chk("mis_htrans_after", 64'(htrans), 64'd0);
            return;
        end
        chk("addr_htrans", 64'(htrans), 64'h2);
        chk("addr_haddr", 64'(haddr), 64'(addr));
        chk("addr_hwrite", 64'(hwrite), 64'(wr));
        chk("addr_hsize", 64'(hsize), 64'({1'b0, sz}));
        hready = 1'b1;
        @(posedge hclk);
        @(negedge hclk);
        chk("data_htrans", 64'(htrans), 64'd0);
        if (wr) chk("data_hwdata", 64'(hwdata), 64'(exp_hwdata));
        if (mode == 2) begin
            hready = 1'b0; hresp = 1'b1;
            @(posedge hclk);
            @(negedge hclk);
            hready = 1'b1; hresp = 1'b1;
            @(posedge hclk);
            #1 hresp = 1'b0;
        end else if (mode == 3) begin
            hready = 1'b0;
            repeat (16) @(posedge hclk);
            #1;
            chk("timeout_req_ready", 64'(req_ready), 64'd1);
            hready = 1'b1;
        end else begin
            for (int i = 0; i < waits; i++) begin
                hready = 1'b0;
                @(posedge hclk);
                @(negedge hclk);
            end
            hready = 1'b1;
            hrdata = rdata;
            @(posedge hclk);
            #1 hrdata = 32'h0;
        end
    endtask

    initial begin
        hrstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        hrdata = 32'h0; hready = 1'b1; hresp = 1'b0;
        repeat (3) @(negedge hclk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_haddr", 64'(haddr), 64'd0);
        chk("rst_pulses", 64'({load_en, store_done, err_valid}), 64'd0);
        chk("rst_hburst", 64'(hburst), 64'd0);
        hrstn = 1'b1;

        txn(0, 2'd2, 0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'h0);
        txn(0, 2'd0, 1, 32'h103, 32'h0, 5'd6, 32'h80123456, 0, 0, 32'hFFFFFF80, 32'h0);
        txn(0, 2'd0, 0, 32'h103, 32'h0, 5'd7, 32'h80123456, 0, 0, 32'h00000080, 32'h0);
        txn(0, 2'd1, 1, 32'h102, 32'h0, 5'd8, 32'h80011234, 0, 0, 32'hFFFF8001, 32'h0);
        txn(0, 2'd1, 0, 32'h102, 32'h0, 5'd9, 32'h80011234, 1, 0, 32'h00008001, 32'h0);
        txn(0, 2'd0, 1, 32'h101, 32'h0, 5'd10, 32'h00007F00, 0, 0, 32'h0000007F, 32'h0);
        txn(1, 2'd0, 0, 32'h201, 32'h1234565A, 5'd0, 32'h0, 2, 0, 32'h0, 32'h5A5A5A5A);
        txn(1, 2'd1, 0, 32'h202, 32'hFFFFBEEF, 5'd0, 32'h0, 0, 0, 32'h0, 32'hBEEFBEEF);
        txn(0, 2'd2, 0, 32'h102, 32'h0, 5'd11, 32'h0, 0, 1, 32'h0, 32'h0);
        txn(0, 2'd1, 0, 32'h101, 32'h0, 5'd12, 32'h0, 0, 1, 32'h0, 32'h0);
        txn(0, 2'd3, 0, 32'h108, 32'h0, 5'd13, 32'h0, 0, 1, 32'h0, 32'h0);
        txn(0, 2'd2, 0, 32'h300, 32'h0, 5'd14, 32'h0, 0, 2, 32'h0, 32'h0);

        // reset while in the data phase: no completion pulse, bus back to IDLE
        @(negedge hclk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h400; req_rd = 5'd15;
        @(posedge hclk);
        @(negedge hclk);
        req_valid = 1'b0;
        @(posedge hclk);
        @(negedge hclk);
        hready = 1'b0;
        hrstn  = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_htrans", 64'(htrans), 64'd0);
        chk("midrst_outputs", 64'({load_en, store_done, err_valid, err_code}), 64'd0);
        @(posedge hclk);
        @(negedge hclk);
        hready = 1'b1;
        hrstn  = 1'b1;

`ifdef LSU_TIMEOUT_EN
        txn(0, 2'd2, 0, 32'h500, 32'h0, 5'd16, 32'h0, 0, 3, 32'h0, 32'h0);
`else
        txn(0, 2'd2, 0, 32'h500, 32'h0, 5'd16, 32'hCAFEF00D, 20, 0, 32'hCAFEF00D, 32'h0);
`endif
        txn(0, 2'd2, 0, 32'h504, 32'h0, 5'd17, 32'h01020304, 0, 0, 32'h01020304, 32'h0);

        repeat (6) @(negedge hclk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected under 200000", $time);
        $fatal(1);
    end

endmodule
